// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline sequencer (master) and the pipeline
// stages / registers it steers (slave).
interface pipe_hazard_ctrl_if #(
    parameter int PC_WIDTH = 32,
    parameter int REG_W    = 5
);
    logic [REG_W-1:0]    id_rs1;
    logic [REG_W-1:0]    id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_W-1:0]    ex_rd;
    logic                ex_mem_read;
    logic                ex_branch_taken;
    logic [PC_WIDTH-1:0] ex_branch_target;
    logic                ex_halt;
    logic                mem_req;
    logic                mem_ready;

    logic                pc_stall;
    logic                if_id_stall;
    logic                if_id_flush;
    logic                id_ex_stall;
    logic                id_ex_flush;
    logic                ex_mem_stall;
    logic                work_ena;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                halted;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_branch_target, ex_halt, mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, work_ena, redirect_valid, redirect_pc, halted
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_branch_target, ex_halt, mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, work_ena, redirect_valid, redirect_pc, halted
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: boot/halt sequencing, load-use, branch and memory-wait control.
// Optional perf counters when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int BOOT_CYCLES = 4,
    parameter int REG_W       = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.master  hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);
    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, HALT} state_t;

    state_t              state;
    logic [CNT_W-1:0]    boot_cnt;
    logic                active;
    logic                mem_hold;
    logic                load_use;

    logic                pc_stall, if_id_stall, if_id_flush;
    logic                id_ex_stall, id_ex_flush, ex_mem_stall;
    logic                work_ena, redirect_valid, halted;
    logic [PC_WIDTH-1:0] redirect_pc;

    assign active   = (state == RUN) || (state == MEM_WAIT);
    // Wait is entered from a request in RUN; once waiting only mem_ready matters.
    assign mem_hold = ((state == RUN) && hz.mem_req && !hz.mem_ready) ||
                      ((state == MEM_WAIT) && !hz.mem_ready);
    assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_W'(0)) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        work_ena       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = {PC_WIDTH{1'b0}};
        halted         = 1'b0;
        case (state)
            BOOT: pc_stall = 1'b1;
            HALT: begin
                pc_stall = 1'b1;
                halted   = 1'b1;
            end
            default: begin
                work_ena = 1'b1;
                if (mem_hold) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end else if (hz.ex_halt) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hz.ex_branch_taken) begin
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = hz.ex_branch_target;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
        endcase
    end

    assign hz.pc_stall       = pc_stall;
    assign hz.if_id_stall    = if_id_stall;
    assign hz.if_id_flush    = if_id_flush;
    assign hz.id_ex_stall    = id_ex_stall;
    assign hz.id_ex_flush    = id_ex_flush;
    assign hz.ex_mem_stall   = ex_mem_stall;
    assign hz.work_ena       = work_ena;
    assign hz.redirect_valid = redirect_valid;
    assign hz.redirect_pc    = redirect_pc;
    assign hz.halted         = halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            boot_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == CNT_W'(BOOT_CYCLES - 1)) state <= RUN;
                    else boot_cnt <= boot_cnt + 1'b1;
                end
                RUN, MEM_WAIT: begin
                    if (mem_hold)        state <= MEM_WAIT;
                    else if (hz.ex_halt) state <= HALT;
                    else                 state <= RUN;
                end
                default: state <= HALT;
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (active && pc_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (if_id_flush && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued as
// each cycle's stimulus is driven and popped when the outputs are sampled mid-cycle.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.PC_WIDTH(32), .REG_W(5)) bus ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    pipe_hazard_ctrl #(.PC_WIDTH(32), .BOOT_CYCLES(4), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .hz(bus),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt));
`else
    pipe_hazard_ctrl #(.PC_WIDTH(32), .BOOT_CYCLES(4), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .hz(bus));
`endif

    typedef struct packed {
        logic        rst_n;
        logic [4:0]  rs1, rs2;
        logic        use1, use2;
        logic [4:0]  rd;
        logic        mrd, br;
        logic [31:0] tgt;
        logic        halt, mreq, mrdy;
    } stim_t;

    typedef struct packed {
        logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
        logic        ex_mem_stall, work_ena, redirect_valid, halted;
        logic [31:0] redirect_pc;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];

    function automatic stim_t s_idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_lu();
        stim_t s = s_idle();
        s.mrd = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.use2 = 1'b1;
        return s;
    endfunction

    function automatic out_t o_boot();
        out_t o = '0;
        o.pc_stall = 1'b1;
        return o;
    endfunction

    function automatic out_t o_idle();
        out_t o = '0;
        o.work_ena = 1'b1;
        return o;
    endfunction

    function automatic out_t o_lu();
        out_t o = o_idle();
        o.pc_stall = 1'b1; o.if_id_stall = 1'b1; o.id_ex_flush = 1'b1;
        return o;
    endfunction

    function automatic out_t o_br(input logic [31:0] t);
        out_t o = o_idle();
        o.if_id_flush = 1'b1; o.id_ex_flush = 1'b1;
        o.redirect_valid = 1'b1; o.redirect_pc = t;
        return o;
    endfunction

    function automatic out_t o_mem();
        out_t o = o_idle();
        o.pc_stall = 1'b1; o.if_id_stall = 1'b1; o.id_ex_stall = 1'b1; o.ex_mem_stall = 1'b1;
        return o;
    endfunction

    function automatic out_t o_hflush();
        out_t o = o_idle();
        o.if_id_flush = 1'b1; o.id_ex_flush = 1'b1;
        return o;
    endfunction

    function automatic out_t o_halted();
        out_t o = '0;
        o.pc_stall = 1'b1; o.halted = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.pc_stall = bus.pc_stall;        o.if_id_stall = bus.if_id_stall;
        o.if_id_flush = bus.if_id_flush;  o.id_ex_stall = bus.id_ex_stall;
        o.id_ex_flush = bus.id_ex_flush;  o.ex_mem_stall = bus.ex_mem_stall;
        o.work_ena = bus.work_ena;        o.redirect_valid = bus.redirect_valid;
        o.halted = bus.halted;            o.redirect_pc = bus.redirect_pc;
        return o;
    endfunction

    // One cycle of stimulus, driven just after the rising edge; expectation queued.
    task automatic apply(input stim_t s, input out_t e);
        @(posedge clk);
        #1;
        rst_n                = s.rst_n;
        bus.id_rs1           = s.rs1;
        bus.id_rs2           = s.rs2;
        bus.id_use_rs1       = s.use1;
        bus.id_use_rs2       = s.use2;
        bus.ex_rd            = s.rd;
        bus.ex_mem_read      = s.mrd;
        bus.ex_branch_taken  = s.br;
        bus.ex_branch_target = s.tgt;
        bus.ex_halt          = s.halt;
        bus.mem_req          = s.mreq;
        bus.mem_ready        = s.mrdy;
        sb.push_back(e);
    endtask

    // Appends a reset pulse plus the boot sequence and first RUN cycle.
    task automatic add_boot(inout stim_t st[$], inout out_t ex[$]);
        stim_t s = s_idle();
        s.rst_n = 1'b0;
        st.push_back(s); ex.push_back(o_boot());
        for (int i = 0; i < 4; i++) begin st.push_back(s_idle()); ex.push_back(o_boot()); end
        st.push_back(s_idle()); ex.push_back(o_idle());
    endtask

    task automatic test_reset();
        stim_t st[$]; out_t ex[$]; out_t got, exp;
        add_boot(st, ex);
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_reset row %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$]; out_t ex[$]; out_t got, exp; stim_t s;
        st.push_back(s_lu());   ex.push_back(o_lu());
        st.push_back(s_idle()); ex.push_back(o_idle());
        s = s_lu(); s.rd = 5'd0; s.rs2 = 5'd0;
        st.push_back(s);        ex.push_back(o_idle());
        s = s_lu(); s.use2 = 1'b0;
        st.push_back(s);        ex.push_back(o_idle());
        s = s_lu(); s.rs2 = 5'd0; s.use2 = 1'b0; s.rs1 = 5'd5; s.use1 = 1'b1;
        st.push_back(s);        ex.push_back(o_lu());
        s = s_lu(); s.mrd = 1'b0;
        st.push_back(s);        ex.push_back(o_idle());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_load_use row %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_branch();
        stim_t st[$]; out_t ex[$]; out_t got, exp; stim_t s;
        s = s_lu(); s.br = 1'b1; s.tgt = 32'h100;
        st.push_back(s);        ex.push_back(o_br(32'h100));
        s = s_idle(); s.tgt = 32'hDEAD_BEEF;
        st.push_back(s);        ex.push_back(o_idle());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_branch row %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[$]; out_t ex[$]; out_t got, exp; stim_t s;
        s = s_idle(); s.mreq = 1'b1; s.br = 1'b1; s.tgt = 32'h200;
        for (int i = 0; i < 3; i++) begin st.push_back(s); ex.push_back(o_mem()); end
        s.mrdy = 1'b1;
        st.push_back(s);        ex.push_back(o_br(32'h200));
        st.push_back(s_idle()); ex.push_back(o_idle());
        s = s_idle(); s.mreq = 1'b1; s.mrdy = 1'b1;
        st.push_back(s);        ex.push_back(o_idle());
        s.mrdy = 1'b0;
        st.push_back(s);        ex.push_back(o_mem());
        s = s_lu(); s.mreq = 1'b1; s.mrdy = 1'b1;
        st.push_back(s);        ex.push_back(o_lu());
        st.push_back(s_idle()); ex.push_back(o_idle());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_mem_wait row %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t st[$]; out_t ex[$]; out_t got, exp; stim_t s;
        s = s_idle(); s.mreq = 1'b1;
        st.push_back(s); ex.push_back(o_mem());
        st.push_back(s); ex.push_back(o_mem());
        add_boot(st, ex);
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_reset_mid_wait row %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_halt();
        stim_t st[$]; out_t ex[$]; out_t got, exp; stim_t s;
        s = s_idle(); s.halt = 1'b1; s.br = 1'b1; s.tgt = 32'h300;
        st.push_back(s); ex.push_back(o_hflush());
        for (int i = 0; i < 4; i++) begin
            s = s_lu();
            s.br = 1'($urandom_range(0, 1)); s.tgt = $urandom;
            s.mreq = 1'($urandom_range(0, 1)); s.halt = 1'($urandom_range(0, 1));
            st.push_back(s); ex.push_back(o_halted());
        end
        add_boot(st, ex);
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_halt row %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_perf();
        stim_t st[$]; out_t ex[$]; out_t got, exp; stim_t s;
        add_boot(st, ex);
        st.push_back(s_lu());   ex.push_back(o_lu());
        st.push_back(s_idle()); ex.push_back(o_idle());
        st.push_back(s_lu());   ex.push_back(o_lu());
        s = s_idle(); s.br = 1'b1; s.tgt = 32'h40;
        st.push_back(s);        ex.push_back(o_br(32'h40));
        st.push_back(s_idle()); ex.push_back(o_idle());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_perf row %0d: got %h expected %h", i, got, exp);
            end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            if (i == 1) begin
                checks++;
                if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
                    errors++;
                    $display("FAIL perf_reset: got stall %0d flush %0d expected 0 0",
                             perf_stall_cnt, perf_flush_cnt);
                end
            end
`endif
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd2 || perf_flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts: got stall %0d flush %0d expected 2 1",
                     perf_stall_cnt, perf_flush_cnt);
        end
`endif
    endtask

    initial begin
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rd = '0; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.ex_branch_target = '0; bus.ex_halt = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_reset_mid_wait();
        test_halt();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
